// File: rtl/ex_seq_pkg.sv
// ----------------------------------------------------------------------------
// ex_seq_pkg
// Shared definitions for the execute-stage ALU sequencer:
//   state_t    : sequencer FSM states (3-bit encoding)
//   XLEN_DEF   : default datapath width
//   ALU_*      : alu2 operation codes
//   SHIFT_ONE  : shift amount used to form the branch offset (imm << 1)
// ----------------------------------------------------------------------------
package ex_seq_pkg;

    localparam int XLEN_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MAIN   = 3'd1,
        S_SHIFT  = 3'd2,
        S_TARGET = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;

    localparam int unsigned SHIFT_ONE = 1;

endpackage

// File: rtl/ex_alu_sequencer_if.sv
// ----------------------------------------------------------------------------
// ex_alu_sequencer_if
// Upstream (decode/regfile) and downstream (memory stage) handshake bundle
// of the execute-stage sequencer.
//   master : the surrounding pipeline (drives op fields, in_valid, out_ready)
//   slave  : the sequencer (drives in_ready, out_valid, result bundle, op_count)
// ----------------------------------------------------------------------------
interface ex_alu_sequencer_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  PC;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  readData1;
    logic [XLEN-1:0]  readData2;
    logic             ALUSrc;
    logic             Branch;
    logic [3:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  ALUResult;
    logic             Zero;
    logic [XLEN-1:0]  immShifted;
    logic [XLEN-1:0]  PCPlusImmShifted;
    logic             BranchTaken;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, PC, imm, readData1, readData2, ALUSrc, Branch, ALUControl, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, immShifted, PCPlusImmShifted, BranchTaken,
               op_count
    );

    modport slave (
        input  in_valid, PC, imm, readData1, readData2, ALUSrc, Branch, ALUControl, out_ready,
        output in_ready, out_valid, ALUResult, Zero, immShifted, PCPlusImmShifted, BranchTaken,
               op_count
    );
endinterface

// File: rtl/alu2.sv
// ----------------------------------------------------------------------------
// alu2
// Two-operand combinational ALU.
//   a, b : operands (shift amount is b[log2(XLEN)-1:0])
//   op   : operation code (ALU_* in ex_seq_pkg); unknown codes yield 0
//   y    : result
// ----------------------------------------------------------------------------
module alu2
    import ex_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] y
);
    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0]        shamt;
    logic signed [XLEN-1:0] a_s;

    assign shamt = b[SH_W-1:0];
    assign a_s   = $signed(a);

    always_comb begin
        y = '0;
        case (op)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_XOR: y = a ^ b;
            ALU_SLL: y = a << shamt;
            ALU_SRL: y = a >> shamt;
            ALU_SUB: y = a - b;
            ALU_SRA: y = a_s >>> shamt;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/ex_alu_sequencer.sv
// ----------------------------------------------------------------------------
// ex_alu_sequencer
// Multi-cycle execute stage: one alu2 is time-shared between the main op,
// the branch offset shift (imm << 1) and the branch target add (PC + offset).
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low
//   flush  : synchronous kill of the in-flight or held op
//   bus    : slave side of ex_alu_sequencer_if (op in, result bundle out,
//            valid/ready on both sides, completed-op counter)
// ----------------------------------------------------------------------------
module ex_alu_sequencer
    import ex_seq_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    ex_alu_sequencer_if.slave bus
);
    state_t           state;

    logic [XLEN-1:0]  pc_r, imm_r, rs1_r, opb_r;
    logic             branch_r;
    logic [3:0]       ctrl_r;

    logic [XLEN-1:0]  alu_res_r, imm_sh_r, target_r;
    logic             zero_r, taken_r;
    logic [CNT_W-1:0] cnt_r;

    logic [XLEN-1:0]  alu_a, alu_b, alu_y;
    logic [3:0]       alu_op;
    logic             in_ready_c, out_valid_c, accept, handoff, alu_zero;

    // Operand selection depends only on the state, never on live inputs.
    always_comb begin
        alu_a  = rs1_r;
        alu_b  = opb_r;
        alu_op = ctrl_r;
        case (state)
            S_SHIFT: begin
                alu_a  = imm_r;
                alu_b  = XLEN'(SHIFT_ONE);
                alu_op = ALU_SLL;
            end
            S_TARGET: begin
                alu_a  = pc_r;
                alu_b  = imm_sh_r;
                alu_op = ALU_ADD;
            end
            default: ;
        endcase
    end

    alu2 #(.XLEN(XLEN)) u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    assign alu_zero    = (alu_y == '0);
    // flush masks both handshakes in the cycle it is asserted.
    assign out_valid_c = (state == S_DONE) && !flush;
    assign in_ready_c  = !flush && ((state == S_IDLE) || ((state == S_DONE) && bus.out_ready));
    assign accept      = bus.in_valid && in_ready_c;
    assign handoff     = out_valid_c && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            pc_r      <= '0;
            imm_r     <= '0;
            rs1_r     <= '0;
            opb_r     <= '0;
            branch_r  <= 1'b0;
            ctrl_r    <= '0;
            alu_res_r <= '0;
            zero_r    <= 1'b0;
            imm_sh_r  <= '0;
            target_r  <= '0;
            taken_r   <= 1'b0;
            cnt_r     <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            if (handoff)
                cnt_r <= cnt_r + CNT_W'(1);

            // Operand capture stage
            if (accept) begin
                pc_r     <= bus.PC;
                imm_r    <= bus.imm;
                rs1_r    <= bus.readData1;
                opb_r    <= bus.ALUSrc ? bus.imm : bus.readData2;
                branch_r <= bus.Branch;
                ctrl_r   <= bus.ALUControl;
            end

            case (state)
                S_IDLE: begin
                    if (accept)
                        state <= S_MAIN;
                end
                // Main op stage
                S_MAIN: begin
                    alu_res_r <= alu_y;
                    zero_r    <= alu_zero;
                    taken_r   <= branch_r && alu_zero;
                    if (branch_r) begin
                        state <= S_SHIFT;
                    end else begin
                        imm_sh_r <= '0;
                        target_r <= '0;
                        state    <= S_DONE;
                    end
                end
                // Branch offset stage
                S_SHIFT: begin
                    imm_sh_r <= alu_y;
                    state    <= S_TARGET;
                end
                // Branch target stage
                S_TARGET: begin
                    target_r <= alu_y;
                    state    <= S_DONE;
                end
                S_DONE: begin
                    if (accept)
                        state <= S_MAIN;
                    else if (handoff)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready         = in_ready_c;
    assign bus.out_valid        = out_valid_c;
    assign bus.ALUResult        = alu_res_r;
    assign bus.Zero             = zero_r;
    assign bus.immShifted       = imm_sh_r;
    assign bus.PCPlusImmShifted = target_r;
    assign bus.BranchTaken      = taken_r;
    assign bus.op_count         = cnt_r;
endmodule

// File: tb/tb_ex_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ex_alu_sequencer
// Table-driven bench for ex_alu_sequencer with a result scoreboard, plus
// hand-written sequences for backpressure, back-to-back issue, flush and
// reset in the middle of an op. A second instance with a 2-bit op_count
// follows the same stimulus so counter wrap-around is observed.
// ----------------------------------------------------------------------------
module tb_ex_alu_sequencer;
    logic clk;
    logic reset;
    logic flush;

    ex_alu_sequencer_if #(.XLEN(64), .CNT_W(32)) bus ();
    ex_alu_sequencer_if #(.XLEN(64), .CNT_W(2))  bus2 ();

    ex_alu_sequencer #(.XLEN(64), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    ex_alu_sequencer #(.XLEN(64), .CNT_W(2)) dut_w (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus2)
    );

    assign bus2.in_valid   = bus.in_valid;
    assign bus2.PC         = bus.PC;
    assign bus2.imm        = bus.imm;
    assign bus2.readData1  = bus.readData1;
    assign bus2.readData2  = bus.readData2;
    assign bus2.ALUSrc     = bus.ALUSrc;
    assign bus2.Branch     = bus.Branch;
    assign bus2.ALUControl = bus.ALUControl;
    assign bus2.out_ready  = bus.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        alusrc;
        logic        branch;
        logic [3:0]  ctrl;
        logic [63:0] res;
        logic        zero;
        logic [63:0] ish;
        logic [63:0] tgt;
        logic        taken;
    } vec_t;

    vec_t        vecs [12];
    vec_t        cur;
    vec_t        sbq [$];
    int          nchk;
    int          nfail;
    logic [31:0] cnt_exp;

    function automatic vec_t mk(input logic [63:0] pc, input logic [63:0] imm,
                                input logic [63:0] rs1, input logic [63:0] rs2,
                                input logic alusrc, input logic branch, input logic [3:0] ctrl,
                                input logic [63:0] res, input logic zero,
                                input logic [63:0] ish, input logic [63:0] tgt, input logic taken);
        vec_t v;
        v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
        v.alusrc = alusrc; v.branch = branch; v.ctrl = ctrl;
        v.res = res; v.zero = zero; v.ish = ish; v.tgt = tgt; v.taken = taken;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.PC         = v.pc;
        bus.imm        = v.imm;
        bus.readData1  = v.rs1;
        bus.readData2  = v.rs2;
        bus.ALUSrc     = v.alusrc;
        bus.Branch     = v.branch;
        bus.ALUControl = v.ctrl;
    endtask

    // One clock: sample handshakes just before the edge, update the
    // scoreboard, advance past the edge and check the counters.
    task automatic step(output logic acc, output logic ho, output logic ov);
        vec_t e;
        #1;
        ov  = bus.out_valid;
        acc = bus.in_valid && bus.in_ready;
        ho  = bus.out_valid && bus.out_ready;
        if (flush)
            sbq.delete();
        if (ho) begin
            if (sbq.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL sb_empty: handoff with no outstanding op, ALUResult 0x%0h", bus.ALUResult);
            end else begin
                e = sbq.pop_front();
                check ("ALUResult",        bus.ALUResult,        e.res);
                check1("Zero",             bus.Zero,             e.zero);
                check ("immShifted",       bus.immShifted,       e.ish);
                check ("PCPlusImmShifted", bus.PCPlusImmShifted, e.tgt);
                check1("BranchTaken",      bus.BranchTaken,      e.taken);
            end
            cnt_exp++;
        end
        if (acc)
            sbq.push_back(cur);
        @(posedge clk);
        #1;
        check("op_count",   64'(bus.op_count),  64'(cnt_exp));
        check("op_count_w", 64'(bus2.op_count), 64'(cnt_exp[1:0]));
    endtask

    task automatic run_op(input int idx, input int hold);
        logic acc, ho, ov;
        int   n, lat;
        cur = vecs[idx];
        drive(cur);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            step(acc, ho, ov);
            n++;
        end
        check1("accepted", acc, 1'b1);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            step(acc, ho, ov);
            lat++;
        end
        check("latency", 64'(lat), 64'(cur.branch ? 4 : 2));
        for (int h = 0; h < hold; h++) begin
            step(acc, ho, ov);
            check1("bp_valid",    ov,            1'b1);
            check ("bp_result",   bus.ALUResult, cur.res);
            check ("bp_target",   bus.PCPlusImmShifted, cur.tgt);
            check1("bp_in_ready", bus.in_ready,  1'b0);
        end
        bus.out_ready = 1'b1;
        step(acc, ho, ov);
        check1("handoff", ho, 1'b1);
        bus.out_ready = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic       acc, ho, ov;
        logic [6:0] p_acc, p_ho;
        nchk    = 0;
        nfail   = 0;
        cnt_exp = '0;

        vecs[0]  = mk(64'h40, 64'h99, 64'd5, 64'd7, 1'b0, 1'b0, 4'b0010, 64'd12, 1'b0, 64'h0, 64'h0, 1'b0);
        vecs[1]  = mk(64'h100, 64'h8, 64'd3, 64'd3, 1'b0, 1'b1, 4'b0110, 64'h0, 1'b1, 64'h10, 64'h110, 1'b1);
        vecs[2]  = mk(64'h200, 64'h20, 64'd5, 64'd3, 1'b0, 1'b1, 4'b0110, 64'd2, 1'b0, 64'h40, 64'h240, 1'b0);
        vecs[3]  = mk(64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 64'd1, 64'd2, 1'b0, 1'b1, 4'b0110,
                      64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h20, 64'h10, 1'b0);
        vecs[4]  = mk(64'h0, 64'h0F, 64'hF0, 64'hFFFF, 1'b1, 1'b0, 4'b0001, 64'hFF, 1'b0, 64'h0, 64'h0, 1'b0);
        vecs[5]  = mk(64'h0, 64'h0, 64'hF0, 64'h0F, 1'b0, 1'b0, 4'b0000, 64'h0, 1'b1, 64'h0, 64'h0, 1'b0);
        vecs[6]  = mk(64'h0, 64'h0, 64'h8000_0000_0000_0000, 64'd4, 1'b0, 1'b0, 4'b0111,
                      64'hF800_0000_0000_0000, 1'b0, 64'h0, 64'h0, 1'b0);
        vecs[7]  = mk(64'h0, 64'd63, 64'd1, 64'd0, 1'b1, 1'b0, 4'b0100,
                      64'h8000_0000_0000_0000, 1'b0, 64'h0, 64'h0, 1'b0);
        vecs[8]  = mk(64'h0, 64'h0, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 1'b0, 4'b0101,
                      64'd1, 1'b0, 64'h0, 64'h0, 1'b0);
        vecs[9]  = mk(64'h0, 64'h0, 64'hFF, 64'hFF, 1'b0, 1'b0, 4'b0011, 64'h0, 1'b1, 64'h0, 64'h0, 1'b0);
        vecs[10] = mk(64'h1000, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 4'b0010,
                      64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFC, 1'b1);
        vecs[11] = mk(64'h20, 64'h10, 64'h10, 64'hAAAA, 1'b1, 1'b1, 4'b0110, 64'h0, 1'b1, 64'h20, 64'h40, 1'b1);

        cur = mk(64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 4'b0, 64'h0, 1'b0, 64'h0, 64'h0, 1'b0);
        drive(cur);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        reset         = 1'b1;
        #1 reset = 1'b0;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check1("rst_out_valid",  bus.out_valid,        1'b0);
        check ("rst_op_count",   64'(bus.op_count),    64'h0);
        check ("rst_ALUResult",  bus.ALUResult,        64'h0);
        check1("rst_Zero",       bus.Zero,             1'b0);
        check ("rst_immShifted", bus.immShifted,       64'h0);
        check ("rst_target",     bus.PCPlusImmShifted, 64'h0);
        check1("rst_taken",      bus.BranchTaken,      1'b0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check1("rst_in_ready", bus.in_ready, 1'b1);

        // Table of single ops
        for (int i = 0; i < 12; i++)
            run_op(i, 0);

        // Backpressure: bundle held stable for 5 cycles
        run_op(2, 5);

        // Back-to-back issue with in_valid and out_ready held high
        p_acc = 7'b0010101;
        p_ho  = 7'b1010100;
        cur   = vecs[0];
        drive(cur);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = (i < 6);
            step(acc, ho, ov);
            check1("b2b_accept",  acc, p_acc[i]);
            check1("b2b_handoff", ho,  p_ho[i]);
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;

        // flush while in SHIFT
        cur = vecs[1];
        drive(cur);
        bus.in_valid = 1'b1;
        step(acc, ho, ov);
        check1("fl_accept", acc, 1'b1);
        bus.in_valid = 1'b0;
        step(acc, ho, ov);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step(acc, ho, ov);
        check1("fl_no_accept", acc, 1'b0);
        check1("fl_no_valid",  ov,  1'b0);
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check1("fl_idle_ready", bus.in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(acc, ho, ov);
            check1("fl_never_valid", ov, 1'b0);
        end

        // flush while DONE with out_ready high: no handoff, count unchanged
        cur = vecs[0];
        drive(cur);
        bus.in_valid = 1'b1;
        step(acc, ho, ov);
        bus.in_valid = 1'b0;
        step(acc, ho, ov);
        check1("fd_done_valid", bus.out_valid, 1'b1);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        step(acc, ho, ov);
        check1("fd_no_valid",  ov,  1'b0);
        check1("fd_no_accept", acc, 1'b0);
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        #1;
        check1("fd_idle_valid", bus.out_valid, 1'b0);

        // Reset asserted while the next op sits in TARGET
        cur = vecs[2];
        drive(cur);
        bus.in_valid = 1'b1;
        step(acc, ho, ov);
        bus.in_valid = 1'b0;
        step(acc, ho, ov);
        step(acc, ho, ov);
        reset = 1'b0;
        #1;
        cnt_exp = '0;
        sbq.delete();
        check1("mr_out_valid",  bus.out_valid,        1'b0);
        check ("mr_op_count",   64'(bus.op_count),    64'h0);
        check ("mr_op_count_w", 64'(bus2.op_count),   64'h0);
        check ("mr_ALUResult",  bus.ALUResult,        64'h0);
        check ("mr_immShifted", bus.immShifted,       64'h0);
        check ("mr_target",     bus.PCPlusImmShifted, 64'h0);
        #2 reset = 1'b1;
        step(acc, ho, ov);
        check1("mr_no_valid", ov, 1'b0);
        #1;
        check1("mr_in_ready", bus.in_ready, 1'b1);

        // Recovery after reset
        run_op(1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
